sd_sector_loader: RTL

Boot-time sequencer that drives the SD single-block read engine to copy a run of consecutive 512-byte sectors into on-chip program/data memory. It sits between the SD read engine and the memory write port. It waits for SD initialisation, issues one read request per sector and counts the 256 16-bit words returned. It writes each word to sequential memory addresses, retries sectors that stall, and reports done or error to the CPU boot logic.

---
 rtl/sd_sector_loader.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_sector_loader.sv
// ---------------------------------------------------------------------------
// sd_sector_loader
//
// Boot-time sequencer that copies a run of consecutive 512-byte SD sectors
// into on-chip memory. It waits for SD initialisation, then issues one
// single-block read request per sector to the SD read engine. Each of the
// 256 16-bit words returned is written to sequential memory word addresses.
// A sector whose request is never acknowledged, or whose word stream stalls,
// is retried from its first word. After too many retries the load ends with
// an error.
//
// Optional feature (compile-time macro SD_LOAD_CHECKSUM_EN):
//   defined   - load_sum accumulates (mod 2^16) every word written in the
//               current pass; a retried sector restores the sum to its value
//               at the start of that sector.
//   undefined - no accumulator is built and load_sum is tied to 0.
//
// Ports:
//   clk          system clock
//   sys_rst      asynchronous active-low reset
//   init_done    SD card initialisation complete (level)
//   load_start   single-cycle start pulse (accepted only when idle)
//   load_sector  first sector number, sampled on accepted load_start
//   load_count   number of sectors, sampled on accepted load_start
//   rd_start     read request to the SD read engine (level)
//   rd_addr      read address (sector number, or byte address)
//   rd_busy      read engine busy
//   rd_en        word-valid strobe from read engine
//   rd_data      word from read engine
//   mem_we       memory write strobe
//   mem_addr     memory word address of the current write
//   mem_wdata    memory write data
//   load_busy    high from accepted start until done/error
//   load_done    one-cycle pulse when all sectors are loaded
//   load_err     sticky error flag, cleared by the next accepted start
//   load_sum     running word checksum (0 when checksum is disabled)
// ---------------------------------------------------------------------------
module sd_sector_loader #(
    parameter int          ADDR_W      = 16,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000,
    parameter int          MAX_RETRY   = 3,
    parameter int          GAP_CYC     = 8,
    parameter int          BLOCK_ADDR  = 1
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              init_done,
    input  logic              load_start,
    input  logic [31:0]       load_sector,
    input  logic [15:0]       load_count,
    output logic              rd_start,
    output logic [31:0]       rd_addr,
    input  logic              rd_busy,
    input  logic              rd_en,
    input  logic [15:0]       rd_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       load_sum
);

    typedef enum logic [2:0] {
        IDLE, WAIT_INIT, REQ, XFER, GAP, DONE, ERR
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [23:0]       TMO_LAST  = TIMEOUT_CYC - 24'd1;
    localparam logic [23:0]       GAP_LAST  = 24'(GAP_CYC - 1);
    localparam logic [7:0]        RETRY_MAX = 8'(MAX_RETRY);

    state_t            state_reg, state_next;
    logic [31:0]       sector_reg, sector_next;
    logic [15:0]       remain_reg, remain_next;
    logic [7:0]        retry_reg, retry_next;
    logic [7:0]        word_cnt_reg, word_cnt_next;
    logic [23:0]       tmo_reg, tmo_next;
    logic [ADDR_W-1:0] wptr_reg, wptr_next;   // address of the next write
    logic [ADDR_W-1:0] base_reg, base_next;   // first word address of sector
    logic              rd_start_reg, rd_start_next;
    logic [31:0]       rd_addr_reg, rd_addr_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [15:0]       mem_wdata_reg, mem_wdata_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic start_acc, word_acc, sector_end, do_retry, tmo_hit;

    assign tmo_hit = (tmo_reg == TMO_LAST);

    always_comb begin
        state_next     = state_reg;
        sector_next    = sector_reg;
        remain_next    = remain_reg;
        retry_next     = retry_reg;
        word_cnt_next  = word_cnt_reg;
        wptr_next      = wptr_reg;
        base_next      = base_reg;
        rd_start_next  = rd_start_reg;
        rd_addr_next   = rd_addr_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        err_next       = err_reg;
        start_acc      = 1'b0;
        word_acc       = 1'b0;
        sector_end     = 1'b0;
        do_retry       = 1'b0;
        tmo_next       = '0;

        case (state_reg)
            IDLE: begin
                if (load_start) begin
                    start_acc     = 1'b1;
                    sector_next   = load_sector;
                    remain_next   = load_count;
                    retry_next    = '0;
                    word_cnt_next = '0;
                    wptr_next     = '0;
                    base_next     = '0;
                    mem_addr_next = '0;
                    err_next      = 1'b0;
                    busy_next     = 1'b1;
                    state_next    = WAIT_INIT;
                end
            end
            WAIT_INIT: begin
                if (init_done) begin
                    if (remain_reg == 16'd0) begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                rd_addr_next = (BLOCK_ADDR != 0) ? sector_reg
                                                 : {sector_reg[22:0], 9'd0};
                if (rd_busy) begin
                    rd_start_next = 1'b0;
                    word_cnt_next = '0;
                    state_next    = XFER;
                end else if (tmo_hit) begin
                    rd_start_next = 1'b0;
                    do_retry      = 1'b1;
                end else begin
                    rd_start_next = 1'b1;
                end
            end
            XFER: begin
                // A word arriving on the timeout cycle wins over the timeout.
                if (rd_en) begin
                    word_acc       = 1'b1;
                    mem_we_next    = 1'b1;
                    mem_wdata_next = rd_data;
                    mem_addr_next  = wptr_reg;
                    wptr_next      = wptr_reg + ADDR_ONE;
                    word_cnt_next  = word_cnt_reg + 8'd1;
                    if (word_cnt_reg == 8'hFF) begin
                        sector_end  = 1'b1;
                        sector_next = sector_reg + 32'd1;
                        remain_next = remain_reg - 16'd1;
                        retry_next  = '0;
                        base_next   = wptr_reg + ADDR_ONE;
                        state_next  = GAP;
                    end
                end else if (tmo_hit) begin
                    do_retry = 1'b1;
                end
            end
            GAP: begin
                if (tmo_reg == GAP_LAST) begin
                    if (remain_reg != 16'd0) begin
                        state_next = REQ;
                    end else begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Retry restarts the sector from its first word.
        if (do_retry) begin
            wptr_next     = base_reg;
            mem_addr_next = base_reg;
            word_cnt_next = '0;
            if (retry_reg == RETRY_MAX) begin
                state_next = ERR;
                busy_next  = 1'b0;
                err_next   = 1'b1;
            end else begin
                retry_next = retry_reg + 8'd1;
                state_next = GAP;
            end
        end

        // Shared counter: timeout in REQ/XFER, gap length in GAP.
        if (state_reg != IDLE && state_next == state_reg && !word_acc)
            tmo_next = tmo_reg + 24'd1;
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_reg     <= IDLE;
            sector_reg    <= '0;
            remain_reg    <= '0;
            retry_reg     <= '0;
            word_cnt_reg  <= '0;
            tmo_reg       <= '0;
            wptr_reg      <= '0;
            base_reg      <= '0;
            rd_start_reg  <= 1'b0;
            rd_addr_reg   <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sector_reg    <= sector_next;
            remain_reg    <= remain_next;
            retry_reg     <= retry_next;
            word_cnt_reg  <= word_cnt_next;
            tmo_reg       <= tmo_next;
            wptr_reg      <= wptr_next;
            base_reg      <= base_next;
            rd_start_reg  <= rd_start_next;
            rd_addr_reg   <= rd_addr_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

`ifdef SD_LOAD_CHECKSUM_EN
    logic [15:0] sum_reg, sum_base_reg;

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sum_reg      <= '0;
            sum_base_reg <= '0;
        end else if (start_acc) begin
            sum_reg      <= '0;
            sum_base_reg <= '0;
        end else if (do_retry) begin
            sum_reg <= sum_base_reg;
        end else if (word_acc) begin
            sum_reg <= sum_reg + rd_data;
            if (sector_end)
                sum_base_reg <= sum_reg + rd_data;
        end
    end

    assign load_sum = sum_reg;
`else
    assign load_sum = 16'd0;
`endif

    assign rd_start  = rd_start_reg;
    assign rd_addr   = rd_addr_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign load_busy = busy_reg;
    assign load_done = done_reg;
    assign load_err  = err_reg;

endmodule
